// File: rtl/animation_pkg.sv
// Shared defaults and state encoding for the LED animation recorder.
package animation_pkg;

  localparam int unsigned DEF_WIDTH = 10;
  localparam int unsigned DEF_DEPTH = 42;
  localparam int unsigned DEF_AW    = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } rec_state_t;

endpackage

// File: rtl/frame_ram.sv
// Frame store: one synchronous write port, one registered read port with sync clear.
module frame_ram #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 42,
  parameter int unsigned AW    = 6
) (
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Clear lives on the output register only, so the array still maps to block RAM.
  always_ff @(posedge CLK) begin
    if (rd_clr)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/animation_recorder.sv
// Records input frames on slow ticks into frame RAM and replays them in a loop on the LEDs.
module animation_recorder
  import animation_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             tick,
  input  logic             rec_btn,
  input  logic             play_btn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             rec_led,
  output logic             play_led,
  output logic             full,
  output logic [AW-1:0]    len
);

  rec_state_t    state, next_state;
  logic          rec_q, play_q;
  logic          rec_e, play_e;
  logic [AW-1:0] wptr, rptr;

  logic start_rec, start_play, clr_dout, do_write, last_write, do_step;

  assign rec_e  = rec_btn  & ~rec_q;
  assign play_e = play_btn & ~play_q;

  // State register
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; rec_e has priority over play_e
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rec_e)                     next_state = RECORD;
        else if (play_e && len != '0)  next_state = PLAY;
      end
      RECORD: begin
        if (rec_e)                                      next_state = IDLE;
        else if (tick && wptr == AW'(DEPTH - 1))        next_state = IDLE;
      end
      PLAY: begin
        if (rec_e)       next_state = RECORD;
        else if (play_e) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control strobes; a button transition suppresses the same-cycle tick action
  always_comb begin
    start_rec  = 1'b0;
    start_play = 1'b0;
    clr_dout   = 1'b0;
    do_write   = 1'b0;
    last_write = 1'b0;
    do_step    = 1'b0;
    case (state)
      IDLE: begin
        start_rec  = rec_e;
        start_play = ~rec_e & play_e & (len != '0);
      end
      RECORD: begin
        do_write   = ~rec_e & tick;
        last_write = ~rec_e & tick & (wptr == AW'(DEPTH - 1));
      end
      PLAY: begin
        start_rec = rec_e;
        clr_dout  = rec_e | play_e;
        do_step   = ~rec_e & ~play_e & tick;
      end
      default: ;
    endcase
  end

  // Button history, pointers, length and status flags
  always_ff @(posedge CLK) begin
    if (reset) begin
      rec_q    <= 1'b0;
      play_q   <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      len      <= '0;
      full     <= 1'b0;
      rec_led  <= 1'b0;
      play_led <= 1'b0;
    end else begin
      rec_q    <= rec_btn;
      play_q   <= play_btn;
      rec_led  <= (next_state == RECORD);
      play_led <= (next_state == PLAY);
      if (start_rec) begin
        wptr <= '0;
        len  <= '0;
        full <= 1'b0;
      end else if (do_write) begin
        wptr <= wptr + AW'(1);
        len  <= len + AW'(1);
        if (last_write) full <= 1'b1;
      end
      if (start_play)   rptr <= '0;
      else if (do_step) rptr <= (rptr == len - AW'(1)) ? '0 : rptr + AW'(1);
    end
  end

  frame_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_frame_ram (
    .CLK     (CLK),
    .wr_en   (do_write),
    .wr_addr (wptr),
    .wr_data (din),
    .rd_en   (do_step),
    .rd_clr  (reset | clr_dout),
    .rd_addr (rptr),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_animation_recorder.sv
// Scoreboard bench for animation_recorder: stimulus queues expectations, a monitor checks them.
module tb_animation_recorder;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned AW    = 6;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             tick = 1'b0;
  logic             rec_btn = 1'b0;
  logic             play_btn = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             rec_led, play_led, full;
  logic [AW-1:0]    len;

  animation_recorder dut (
    .CLK      (CLK),
    .reset    (reset),
    .tick     (tick),
    .rec_btn  (rec_btn),
    .play_btn (play_btn),
    .din      (din),
    .dout     (dout),
    .rec_led  (rec_led),
    .play_led (play_led),
    .full     (full),
    .len      (len)
  );

  always #5 CLK = ~CLK;

  typedef enum int {S_DOUT, S_LEN, S_FULL, S_REC, S_PLAY} sel_t;
  typedef struct {
    int    cyc;
    sel_t  sel;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Expectation for the state visible after the upcoming active edge
  function automatic void expect_val(sel_t sel, int val, string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endfunction

  // Monitor: compare every expectation due this cycle
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      int   act;
      e = q.pop_front();
      case (e.sel)
        S_DOUT:  act = int'(dout);
        S_LEN:   act = int'(len);
        S_FULL:  act = int'(full);
        S_REC:   act = int'(rec_led);
        default: act = int'(play_led);
      endcase
      checks++;
      if (e.cyc != cyc || act != e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d actual=%0h expected=%0h", e.name, cyc, e.cyc, act, e.val);
      end
    end
  end

  task automatic step(input logic rst, input logic rec, input logic play,
                      input logic tk, input logic [WIDTH-1:0] d);
    @(negedge CLK);
    reset    = rst;
    rec_btn  = rec;
    play_btn = play;
    tick     = tk;
    din      = d;
  endtask

  function automatic logic [WIDTH-1:0] frame_of(int i);
    int t;
    t = i * 37 + 5;
    return t[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] seq3 [3];

  initial begin
    seq3[0] = 10'h3FF;
    seq3[1] = 10'h155;
    seq3[2] = 10'h2AA;

    // Reset state
    step(1, 0, 0, 0, '0);
    expect_val(S_DOUT, 0, "rst_dout");
    expect_val(S_LEN, 0, "rst_len");
    expect_val(S_FULL, 0, "rst_full");
    expect_val(S_REC, 0, "rst_rec_led");
    expect_val(S_PLAY, 0, "rst_play_led");
    step(1, 0, 0, 0, '0);

    // 1: play with nothing recorded is refused
    step(0, 0, 1, 0, '0);
    expect_val(S_PLAY, 0, "t1_play_led");
    expect_val(S_DOUT, 0, "t1_dout");
    step(0, 0, 0, 1, '0);
    expect_val(S_DOUT, 0, "t1_dout_tick");

    // 2: record three frames
    step(0, 1, 0, 0, '0);
    expect_val(S_REC, 1, "t2_rec_led_on");
    expect_val(S_LEN, 0, "t2_len0");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, seq3[i]);
      expect_val(S_LEN, i + 1, "t2_len_inc");
      expect_val(S_DOUT, 0, "t2_dout_rec");
    end
    step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    expect_val(S_REC, 0, "t2_rec_led_off");
    expect_val(S_LEN, 3, "t2_len3");
    expect_val(S_FULL, 0, "t2_full0");

    // 3: loop playback of the three frames
    step(0, 0, 1, 0, '0);
    expect_val(S_PLAY, 1, "t3_play_led");
    expect_val(S_DOUT, 0, "t3_dout_entry");
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 1, '0);
      expect_val(S_DOUT, int'(seq3[k % 3]), "t3_dout_seq");
      step(0, 0, 0, 0, '0);
      expect_val(S_DOUT, int'(seq3[k % 3]), "t3_dout_hold");
    end
    step(0, 0, 1, 0, '0);
    expect_val(S_PLAY, 0, "t3_play_off");
    expect_val(S_DOUT, 0, "t3_dout_clr");

    // 5: simultaneous rec/play edges plus tick in IDLE -> RECORD, nothing written
    step(0, 1, 1, 1, 10'h0AB);
    expect_val(S_REC, 1, "t5_rec_led");
    expect_val(S_PLAY, 0, "t5_play_led");
    expect_val(S_LEN, 0, "t5_len0");
    step(0, 0, 0, 0, '0);
    expect_val(S_LEN, 0, "t5_len_still0");
    step(0, 1, 0, 0, '0);
    expect_val(S_REC, 0, "t5_rec_off");
    expect_val(S_LEN, 0, "t5_len_end");
    step(0, 0, 1, 0, '0);
    expect_val(S_PLAY, 0, "t5_play_refused");

    // 4: overfill the RAM; recording stops at DEPTH frames
    step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    expect_val(S_REC, 1, "t4_rec_on");
    for (int i = 1; i <= 45; i++) begin
      step(0, 0, 0, 1, frame_of(i));
      if (i == 41) begin
        expect_val(S_FULL, 0, "t4_full_41");
        expect_val(S_LEN, 41, "t4_len_41");
      end
      if (i == 42) begin
        expect_val(S_FULL, 1, "t4_full_42");
        expect_val(S_LEN, 42, "t4_len_42");
        expect_val(S_REC, 0, "t4_rec_off_42");
      end
    end
    expect_val(S_LEN, 42, "t4_len_end");
    expect_val(S_FULL, 1, "t4_full_end");
    step(0, 0, 1, 0, '0);
    expect_val(S_PLAY, 1, "t4_play_on");
    for (int k = 0; k < 45; k++) begin
      step(0, 0, 0, 1, '0);
      expect_val(S_DOUT, int'(frame_of((k % 42) + 1)), "t4_play_frame");
    end

    // 6: reset mid-PLAY aborts and forgets the recording
    step(1, 0, 0, 0, '0);
    expect_val(S_DOUT, 0, "t6_dout_rst");
    expect_val(S_LEN, 0, "t6_len_rst");
    expect_val(S_PLAY, 0, "t6_play_rst");
    expect_val(S_FULL, 0, "t6_full_rst");
    step(0, 0, 1, 0, '0);
    expect_val(S_PLAY, 0, "t6_play_refused");
    step(0, 0, 0, 1, '0);
    expect_val(S_DOUT, 0, "t6_dout_after");

    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog cyc=%0d expected completion", cyc);
      $fatal(1, "watchdog expired");
    end
  end

endmodule
